// File: rtl/cl_crawler_scheduler.sv
// cl_crawler_scheduler: sequences one anti-diagonal crawler per PairHMM job with dependency/backpressure throttling (optional perf counters: CL_SCHED_PERF_EN)
module cl_crawler_scheduler #(
  parameter int DIM_W = 8,
  parameter int MAX_OUTSTANDING = 16,
  localparam int OCNT_W = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             job_valid_i,
  output logic             job_ready_o,
  input  logic [DIM_W-1:0] job_dim_x_i,
  input  logic [DIM_W-1:0] job_dim_y_i,
  input  logic             abort_i,
  output logic             crawler_enable_o,
  output logic [DIM_W-1:0] crawler_dim_x_o,
  output logic [DIM_W-1:0] crawler_dim_y_o,
  output logic             crawler_move_o,
  input  logic [DIM_W-1:0] crawler_pos_x_i,
  input  logic [DIM_W-1:0] crawler_pos_y_i,
  output logic             cell_valid_o,
  input  logic             cell_ready_i,
  output logic [DIM_W-1:0] cell_x_o,
  output logic [DIM_W-1:0] cell_y_o,
  output logic             cell_last_o,
  input  logic             cell_done_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             done_aborted_o,
  output logic             err_o
`ifdef CL_SCHED_PERF_EN
  ,
  output logic [31:0]      perf_cycles_o,
  output logic [31:0]      perf_dep_stall_o,
  output logic [31:0]      perf_bp_stall_o
`endif
);
  typedef enum logic [2:0] {IDLE, RUN, DRAIN, FLUSH, DONE} state_t;
  localparam logic [OCNT_W-1:0] MAX_O = OCNT_W'(MAX_OUTSTANDING);
  state_t state_q;
  logic [DIM_W-1:0] dim_x_q, dim_y_q;
  logic [OCNT_W-1:0] ocnt_q;
  logic diag_first_q, aborted_q, err_q;
  logic fire, at_edge, last, dec, job_fire;
  assign job_fire = (state_q == IDLE) && job_valid_i;
  assign at_edge = (crawler_pos_x_i == '0) || (crawler_pos_y_i == dim_y_q);
  assign last = (crawler_pos_x_i == dim_x_q) && (crawler_pos_y_i == dim_y_q);
  assign cell_valid_o = (state_q == RUN) && !(diag_first_q && ocnt_q != '0) && (ocnt_q < MAX_O);
  assign fire = cell_valid_o && cell_ready_i;
  assign dec = cell_done_i && (ocnt_q != '0);
  assign crawler_move_o = fire && !last;
  assign cell_x_o = crawler_pos_x_i;
  assign cell_y_o = crawler_pos_y_i;
  assign cell_last_o = cell_valid_o && last;
  assign crawler_dim_x_o = dim_x_q;
  assign crawler_dim_y_o = dim_y_q;
  assign job_ready_o = state_q == IDLE;
  assign busy_o = state_q != IDLE;
  assign crawler_enable_o = (state_q == RUN) || (state_q == DRAIN) || (state_q == FLUSH);
  assign done_o = state_q == DONE;
  assign done_aborted_o = (state_q == DONE) && aborted_q;
  assign err_o = err_q;
  // job FSM plus outstanding-cell tracking; a fire closing an anti-diagonal arms the drain wait for the next one
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      dim_x_q <= '0;
      dim_y_q <= '0;
      ocnt_q <= '0;
      diag_first_q <= 1'b0;
      aborted_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      ocnt_q <= ocnt_q + OCNT_W'(fire) - OCNT_W'(dec);
      if (cell_done_i && ocnt_q == '0) err_q <= 1'b1;
      if (fire) diag_first_q <= at_edge && !last;
      case (state_q)
        IDLE: if (job_valid_i) begin
          state_q <= RUN;
          dim_x_q <= job_dim_x_i;
          dim_y_q <= job_dim_y_i;
          diag_first_q <= 1'b1;
          aborted_q <= 1'b0;
        end
        RUN: state_q <= abort_i ? FLUSH : (fire && last) ? DRAIN : RUN;
        DRAIN: state_q <= abort_i ? FLUSH : (ocnt_q == '0) ? DONE : DRAIN;
        FLUSH: if (ocnt_q == '0) begin
          state_q <= DONE;
          aborted_q <= 1'b1;
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
`ifdef CL_SCHED_PERF_EN
  logic [31:0] perf_cycles_q, perf_dep_q, perf_bp_q;
  logic in_run;
  assign in_run = state_q == RUN;
  assign perf_cycles_o = perf_cycles_q;
  assign perf_dep_stall_o = perf_dep_q;
  assign perf_bp_stall_o = perf_bp_q;
  // saturating per-job counters: active cycles, dependency/limit stalls, downstream backpressure stalls
  always_ff @(posedge clock_i) begin
    if (reset_i || job_fire) begin
      perf_cycles_q <= '0;
      perf_dep_q <= '0;
      perf_bp_q <= '0;
    end else begin
      if ((in_run || state_q == DRAIN) && !(&perf_cycles_q)) perf_cycles_q <= perf_cycles_q + 32'd1;
      if (in_run && !cell_valid_o && !(&perf_dep_q)) perf_dep_q <= perf_dep_q + 32'd1;
      if (in_run && cell_valid_o && !cell_ready_i && !(&perf_bp_q)) perf_bp_q <= perf_bp_q + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_cl_crawler_scheduler.sv
// tb_cl_crawler_scheduler: randomized bench with a queue-based job model, a zigzag crawler stand-in and literal pins
module tb_cl_crawler_scheduler;
  localparam int DW = 8;
  localparam int MO = 3;
  logic clock_i = 1'b0;
  logic reset_i, job_valid_i, job_ready_o, abort_i, crawler_enable_o, crawler_move_o;
  logic cell_valid_o, cell_ready_i, cell_last_o, cell_done_i, busy_o, done_o, done_aborted_o, err_o;
  logic [DW-1:0] job_dim_x_i, job_dim_y_i, crawler_dim_x_o, crawler_dim_y_o;
  logic [DW-1:0] crawler_pos_x_i, crawler_pos_y_i, cell_x_o, cell_y_o;
  always #5 clock_i = ~clock_i;
  cl_crawler_scheduler #(.DIM_W(DW), .MAX_OUTSTANDING(MO)) dut (
    .clock_i(clock_i), .reset_i(reset_i), .job_valid_i(job_valid_i), .job_ready_o(job_ready_o),
    .job_dim_x_i(job_dim_x_i), .job_dim_y_i(job_dim_y_i), .abort_i(abort_i),
    .crawler_enable_o(crawler_enable_o), .crawler_dim_x_o(crawler_dim_x_o), .crawler_dim_y_o(crawler_dim_y_o),
    .crawler_move_o(crawler_move_o), .crawler_pos_x_i(crawler_pos_x_i), .crawler_pos_y_i(crawler_pos_y_i),
    .cell_valid_o(cell_valid_o), .cell_ready_i(cell_ready_i), .cell_x_o(cell_x_o), .cell_y_o(cell_y_o),
    .cell_last_o(cell_last_o), .cell_done_i(cell_done_i), .busy_o(busy_o), .done_o(done_o),
    .done_aborted_o(done_aborted_o), .err_o(err_o));
  int checks = 0, errors = 0, cyc = 0;
  logic jv = 0, ab = 0, rst_req = 0, force_done = 0;
  int jdx = 0, jdy = 0, rmode = 0, lat_lo = 4, lat_hi = 4, abort_pct = 0;
  int cx = 0, cy = 0;
  int ph = 0, outs = 0, mdx = 0, mdy = 0;
  bit m_abt = 0, m_err = 0;
  int qx[$], qy[$];
  bit qf[$];
  int due[$];
  int nfire, ndone, nabt, nmove, last_done_cyc, done_cyc, peak, dout;
  int log_q[$];
  int exp33[9] = '{'h00, 'h10, 'h01, 'h20, 'h11, 'h02, 'h21, 'h12, 'h22};
  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", n, a, e, cyc);
    end
  endtask
  task automatic build_cells();
    qx.delete(); qy.delete(); qf.delete();
    for (int d = 0; d <= mdx + mdy; d++) begin
      int hi;
      hi = d < mdx ? d : mdx;
      for (int x = hi; x >= 0 && d - x <= mdy; x--) begin
        qx.push_back(x); qy.push_back(d - x); qf.push_back(x == hi);
      end
    end
  endtask
  task automatic step();
    bit dn, ev, lastc, fire;
    int idx, nouts, d, dimx, dimy;
    reset_i = rst_req; job_valid_i = jv; abort_i = ab;
    job_dim_x_i = jdx[DW-1:0]; job_dim_y_i = jdy[DW-1:0];
    cell_ready_i = rmode == 0 ? 1'b1 : rmode == 1 ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
    idx = -1;
    foreach (due[i]) if (idx < 0 && due[i] <= cyc) idx = i;
    dn = force_done || idx >= 0;
    if (idx >= 0) due.delete(idx);
    cell_done_i = dn;
    crawler_pos_x_i = cx[DW-1:0]; crawler_pos_y_i = cy[DW-1:0];
    @(negedge clock_i);
    ev = ph == 1 && qx.size() > 0 && !(qf[0] && outs != 0) && outs < MO;
    lastc = ev && qx[0] == mdx && qy[0] == mdy;
    fire = ev && cell_ready_i;
    chk("job_ready", job_ready_o, ph == 0);
    chk("busy", busy_o, ph != 0);
    chk("crawler_enable", crawler_enable_o, ph >= 1 && ph <= 3);
    chk("done", done_o, ph == 4);
    chk("done_aborted", done_aborted_o, ph == 4 && m_abt);
    chk("err", err_o, m_err);
    chk("cell_valid", cell_valid_o, ev);
    chk("cell_last", cell_last_o, lastc);
    chk("crawler_move", crawler_move_o, fire && !lastc);
    if (ev) begin
      chk("cell_x", cell_x_o, qx[0]);
      chk("cell_y", cell_y_o, qy[0]);
    end
    if (ph != 0) begin
      chk("crawler_dim_x", crawler_dim_x_o, mdx);
      chk("crawler_dim_y", crawler_dim_y_o, mdy);
    end
    if (cell_valid_o && cell_ready_i) begin
      nfire++;
      log_q.push_back(int'(cell_x_o) * 16 + int'(cell_y_o));
    end
    if (done_o) begin ndone++; done_cyc = cyc; end
    if (done_aborted_o) nabt++;
    if (crawler_move_o) nmove++;
    if (dn) last_done_cyc = cyc;
    dout = rst_req ? 0 : dout + int'(cell_valid_o && cell_ready_i) - int'(dn && dout > 0);
    if (dout > peak) peak = dout;
    dimx = int'(crawler_dim_x_o); dimy = int'(crawler_dim_y_o);
    if (!crawler_enable_o) begin cx = 0; cy = 0; end
    else if (crawler_move_o) begin
      if (cx == 0 || cy == dimy) begin
        d = cx + cy + 1; cx = d < dimx ? d : dimx; cy = d - cx;
      end else begin
        cx--; cy++;
      end
    end
    if (rst_req) begin
      ph = 0; outs = 0; m_err = 0; m_abt = 0;
    end else begin
      if (dn && outs == 0) m_err = 1;
      nouts = outs + int'(fire) - int'(dn && outs != 0);
      if (fire) begin
        void'(qx.pop_front()); void'(qy.pop_front()); void'(qf.pop_front());
        due.push_back(cyc + $urandom_range(lat_lo, lat_hi));
      end
      case (ph)
        0: if (jv) begin ph = 1; mdx = jdx; mdy = jdy; m_abt = 0; build_cells(); end
        1: if (ab) ph = 3; else if (fire && lastc) ph = 2;
        2: if (ab) ph = 3; else if (outs == 0) ph = 4;
        3: if (outs == 0) begin ph = 4; m_abt = 1; end
        default: ph = 0;
      endcase
      outs = nouts;
    end
    @(posedge clock_i);
    #1;
    cyc++;
  endtask
  task automatic run_job(int dx, int dy, int abort_outs);
    int n;
    n = 0; jdx = dx; jdy = dy;
    nfire = 0; ndone = 0; nabt = 0; nmove = 0; peak = 0; last_done_cyc = -1; done_cyc = -1;
    log_q.delete();
    jv = 1; step(); jv = 0;
    while (ph != 0 && n < 3000) begin
      ab = (abort_outs > 0 && ph == 1 && outs == abort_outs) || (abort_pct > 0 && $urandom_range(0, 99) < abort_pct);
      step();
      n++;
    end
    ab = 0;
    chk("job_completes_in_budget", ph == 0, 1);
  endtask
  initial begin
    int dups;
    dout = 0;
    rst_req = 1; step(); step(); rst_req = 0;
    chk("rst_job_ready", job_ready_o, 1);
    chk("rst_busy", busy_o, 0);
    chk("rst_cell_valid", cell_valid_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_enable", crawler_enable_o, 0);
    rmode = 0; lat_lo = 4; lat_hi = 4;
    run_job(2, 2, 0);
    chk("3x3_fires", nfire, 9);
    for (int i = 0; i < 9 && i < log_q.size(); i++) chk("3x3_order", log_q[i], exp33[i]);
    chk("3x3_done_pulses", ndone, 1);
    chk("3x3_aborted", nabt, 0);
    run_job(0, 0, 0);
    chk("1x1_fires", nfire, 1);
    chk("1x1_moves", nmove, 0);
    chk("1x1_done_latency", done_cyc - last_done_cyc, 2);
    lat_lo = 25; lat_hi = 25;
    run_job(7, 7, 0);
    chk("cap_peak_outstanding", peak, MO);
    chk("cap_fires", nfire, 64);
    rmode = 1; lat_lo = 1; lat_hi = 3;
    run_job(3, 1, 0);
    chk("toggle_fires", nfire, 8);
    dups = 0;
    foreach (log_q[i]) for (int j = i + 1; j < log_q.size(); j++) if (log_q[i] == log_q[j]) dups++;
    chk("toggle_duplicates", dups, 0);
    rmode = 0; lat_lo = 20; lat_hi = 20;
    run_job(7, 7, 3);
    chk("abort_done_pulses", ndone, 1);
    chk("abort_flagged", nabt, 1);
    chk("abort_fires", nfire, 6);
    chk("abort_then_ready", job_ready_o, 1);
    rmode = 2; lat_lo = 1; lat_hi = 6; abort_pct = 3;
    for (int k = 0; k < 25; k++) run_job($urandom_range(0, 5), $urandom_range(0, 5), 0);
    abort_pct = 0; rmode = 0;
    force_done = 1; step(); force_done = 0;
    for (int k = 0; k < 4; k++) step();
    chk("err_sticky", err_o, 1);
    lat_lo = 8; lat_hi = 8; jdx = 7; jdy = 7;
    jv = 1; step(); jv = 0;
    for (int k = 0; k < 3; k++) step();
    rst_req = 1; step(); rst_req = 0;
    chk("midrst_job_ready", job_ready_o, 1);
    chk("midrst_enable", crawler_enable_o, 0);
    chk("midrst_err_cleared", err_o, 0);
    for (int k = 0; k < 15; k++) step();
    chk("midrst_late_done_err", err_o, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
